// File: rtl/full_half_adder_1bit_if.sv
// ---------------------------------------------------------------------------
// full_half_adder_1bit_if
//
// Operand/result bundle for the single-bit full adder cell.
//
// Signals:
//   i_valid  operand set on i_a/i_b/i_cin is valid this cycle
//   i_a      operand A
//   i_b      operand B
//   i_cin    carry-in
//   o_sum    sum bit (A ^ B ^ Cin)
//   o_carry  carry-out (majority of A, B, Cin)
//   o_valid  o_sum/o_carry belong to a valid operand set
//
// Modports:
//   master  the operand source: drives the i_* signals, observes the o_* ones
//   slave   the adder cell: observes the i_* signals, drives the o_* ones
// ---------------------------------------------------------------------------
interface full_half_adder_1bit_if;
    logic i_valid;
    logic i_a;
    logic i_b;
    logic i_cin;
    logic o_sum;
    logic o_carry;
    logic o_valid;

    modport master (
        output i_valid,
        output i_a,
        output i_b,
        output i_cin,
        input  o_sum,
        input  o_carry,
        input  o_valid
    );

    modport slave (
        input  i_valid,
        input  i_a,
        input  i_b,
        input  i_cin,
        output o_sum,
        output o_carry,
        output o_valid
    );
endinterface

// File: rtl/full_half_adder_1bit.sv
// ---------------------------------------------------------------------------
// full_half_adder_1bit
//
// Single-bit full adder built from two half-adder stages plus an OR-merge of
// the two partial carries. It is the leaf cell for ripple-carry adders.
// {o_carry, o_sum} equals i_a + i_b + i_cin.
//
// Parameters:
//   OUT_REG  1 = results registered on i_clk (latency 1)
//            0 = results purely combinational; reset only masks o_valid
//
// Ports:
//   i_clk    clock, rising-edge active
//   i_rst_n  asynchronous active-low reset
//   bus      slave side of full_half_adder_1bit_if (operands in, results out)
//
// Also contains half_adder, the two-input sum/carry cell used twice here.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// half_adder
//
// Two-input half adder.
//
// Ports:
//   a, b   operand bits
//   s      sum   = a ^ b
//   c      carry = a & b
// ---------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_half_adder_1bit #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    full_half_adder_1bit_if.slave bus
);

    // Stage p0: two cascaded half adders and carry merge (combinational).
    logic s0_p0;
    logic c0_p0;
    logic s1_p0;
    logic c1_p0;
    logic sum_p0;
    logic carry_p0;
    logic vld_p0;

    half_adder u_ha0 (
        .a (bus.i_a),
        .b (bus.i_b),
        .s (s0_p0),
        .c (c0_p0)
    );

    half_adder u_ha1 (
        .a (s0_p0),
        .b (bus.i_cin),
        .s (s1_p0),
        .c (c1_p0)
    );

    // The two partial carries can never both be 1 (c0 needs a=b=1, which
    // forces s0=0 and hence c1=0), so OR and XOR would both work; OR is the
    // conventional merge.
    assign sum_p0   = s1_p0;
    assign carry_p0 = c0_p0 | c1_p0;
    assign vld_p0   = bus.i_valid;

    generate
        if (OUT_REG) begin : g_reg
            // Stage p1: output registers. Data loads every cycle; o_valid
            // qualifies it. Reset clears all three so nothing stale is
            // presented after reset.
            logic sum_p1;
            logic carry_p1;
            logic vld_p1;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sum_p1   <= 1'b0;
                    carry_p1 <= 1'b0;
                    vld_p1   <= 1'b0;
                end else begin
                    sum_p1   <= sum_p0;
                    carry_p1 <= carry_p0;
                    vld_p1   <= vld_p0;
                end
            end

            assign bus.o_sum   = sum_p1;
            assign bus.o_carry = carry_p1;
            assign bus.o_valid = vld_p1;
        end else begin : g_comb
            // Clock is not needed in the combinational build.
            logic clk_unused;
            assign clk_unused = i_clk;

            // Reset only masks the valid flag; data follows the inputs.
            assign bus.o_sum   = sum_p0;
            assign bus.o_carry = carry_p0;
            assign bus.o_valid = vld_p0 & i_rst_n;
        end
    endgenerate

endmodule

// File: tb/tb_full_half_adder_1bit.sv
// ---------------------------------------------------------------------------
// tb_full_half_adder_1bit
//
// Directed and random checks of full_half_adder_1bit in its registered
// (OUT_REG=1) and combinational (OUT_REG=0) builds.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_full_half_adder_1bit;

    logic clk;
    logic rst_n;

    full_half_adder_1bit_if bus_r ();
    full_half_adder_1bit_if bus_c ();

    full_half_adder_1bit #(.OUT_REG(1'b1)) u_dut_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_r.slave)
    );

    full_half_adder_1bit #(.OUT_REG(1'b0)) u_dut_comb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_r(input logic v, input logic a, input logic b, input logic c);
        bus_r.i_valid = v;
        bus_r.i_a     = a;
        bus_r.i_b     = b;
        bus_r.i_cin   = c;
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed {carry,sum} for (a,b,cin) = 000..111
    logic [1:0] exh_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                2'b01, 2'b10, 2'b10, 2'b11};

    // Valid-gating vectors: {valid,a,b,cin} and expected {valid,carry,sum}
    logic [3:0] vg_in  [3] = '{4'b1101, 4'b0000, 4'b1010};
    logic [2:0] vg_exp [3] = '{3'b110, 3'b000, 3'b101};

    initial begin
        logic [2:0] abc;
        logic [1:0] ref_val;
        logic ra, rb, rc;

        rst_n = 1'b0;
        drive_r(1'b1, 1'b1, 1'b1, 1'b1);
        bus_c.i_valid = 1'b1;
        bus_c.i_a     = 1'b1;
        bus_c.i_b     = 1'b0;
        bus_c.i_cin   = 1'b1;

        // Reset held while clocking with all-ones operands
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold_cs", {bus_r.o_carry, bus_r.o_sum}, 2'b00);
            check("rst_hold_vld", {1'b0, bus_r.o_valid}, 2'b00);
        end

        // Combinational build during reset: data follows, valid masked
        check("comb_rst_cs", {bus_c.o_carry, bus_c.o_sum}, 2'b10);
        check("comb_rst_vld", {1'b0, bus_c.o_valid}, 2'b00);

        // Release between edges; first load on the next edge
        #2 rst_n = 1'b1;
        step();
        check("post_rst_cs", {bus_r.o_carry, bus_r.o_sum}, 2'b11);
        check("post_rst_vld", {1'b0, bus_r.o_valid}, 2'b01);

        // Combinational build, no clock edge needed: (1,0,1) -> carry 1 sum 0
        #1;
        check("comb_101_cs", {bus_c.o_carry, bus_c.o_sum}, 2'b10);
        check("comb_101_vld", {1'b0, bus_c.o_valid}, 2'b01);
        bus_c.i_a = 1'b1; bus_c.i_b = 1'b1; bus_c.i_cin = 1'b1; bus_c.i_valid = 1'b0;
        #1;
        check("comb_111_cs", {bus_c.o_carry, bus_c.o_sum}, 2'b11);
        check("comb_nv_vld", {1'b0, bus_c.o_valid}, 2'b00);

        // Asynchronous reset between edges clears outputs immediately
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", {bus_r.o_carry, bus_r.o_sum}, 2'b00);
        check("async_rst_vld", {1'b0, bus_r.o_valid}, 2'b00);
        #1 rst_n = 1'b1;

        // Exhaustive sweep, back-to-back valid
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            drive_r(1'b1, abc[2], abc[1], abc[0]);
            step();
            check($sformatf("exh_%b_cs", abc), {bus_r.o_carry, bus_r.o_sum}, exh_exp[i]);
            check($sformatf("exh_%b_vld", abc), {1'b0, bus_r.o_valid}, 2'b01);
        end

        // Boundary vectors
        drive_r(1'b1, 1'b0, 1'b0, 1'b0); step();
        check("bnd_000", {bus_r.o_carry, bus_r.o_sum}, 2'b00);
        drive_r(1'b1, 1'b1, 1'b1, 1'b1); step();
        check("bnd_111", {bus_r.o_carry, bus_r.o_sum}, 2'b11);
        drive_r(1'b1, 1'b1, 1'b1, 1'b0); step();
        check("bnd_110", {bus_r.o_carry, bus_r.o_sum}, 2'b10);

        // Valid gating: data still loads when i_valid is low
        for (int i = 0; i < 3; i++) begin
            drive_r(vg_in[i][3], vg_in[i][2], vg_in[i][1], vg_in[i][0]);
            step();
            check($sformatf("vg%0d_cs", i), {bus_r.o_carry, bus_r.o_sum}, vg_exp[i][1:0]);
            check($sformatf("vg%0d_vld", i), {1'b0, bus_r.o_valid}, {1'b0, vg_exp[i][2]});
        end

        // Random operands against an arithmetic reference
        for (int i = 0; i < 100; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ref_val = 2'(ra) + 2'(rb) + 2'(rc);
            drive_r(1'b1, ra, rb, rc);
            step();
            check($sformatf("rnd%0d", i), {bus_r.o_carry, bus_r.o_sum}, ref_val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
